spike_rate_encoder: RTL and testbench

- Upstream stage of the LIF neuron network.
- Converts per-channel intensity values into rate-coded one-bit spike trains on a fixed timestep grid.
- Spike trains drive the network's 8 input lines.
- Intensities are written over a simple indexed load port. A prescaler defines the simulation timestep. A per-channel phase accumulator emits a spike on each overflow.

---
 rtl/snn_pkg.sv | 24 ++
 rtl/spike_enc_channel.sv | 62 ++++++
 rtl/spike_rate_encoder.sv | 100 ++++++++++
 tb/tb_spike_rate_encoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants, types and LFSR helpers for the spiking-network front end.
// Latency: n/a (package). Backpressure: n/a.
// Optional feature macro used by clients: SPIKE_ENC_STOCHASTIC_EN.
package snn_pkg;

    localparam int NUM_CH_DEF = 8;
    localparam int INT_W_DEF  = 4;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

    typedef logic [INT_W_DEF-1:0] intensity_t;
    typedef logic [LFSR_W-1:0]    lfsr_t;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting toward the LSB.
    function automatic lfsr_t lfsr_next(input lfsr_t s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : lfsr_t'(0));
    endfunction

    function automatic lfsr_t lfsr_rotl(input lfsr_t s, input int sh);
        return (s << sh) | (s >> (LFSR_W - sh));
    endfunction

endpackage

// File: rtl/spike_enc_channel.sv
// One rate-coded channel: intensity register, phase accumulator and spike decision.
// Latency: spike registered 1 cycle after the tick event. Backpressure: none (free-running).
// With SPIKE_ENC_STOCHASTIC_EN the decision is an LFSR compare instead of the accumulator carry.
module spike_enc_channel
    import snn_pkg::*;
#(
    parameter int INT_W = INT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_evt,
    input  logic             clr_evt,
    input  logic             wr,
    input  logic [INT_W-1:0] wr_val,
`ifdef SPIKE_ENC_STOCHASTIC_EN
    input  logic [INT_W-1:0] rnd,
`endif
    output logic             spike
);

    logic [INT_W-1:0] intensity;
    logic             fire;

    // Loads are independent of enable and clear; a load coinciding with a
    // tick lands after the accumulation, so that tick still uses the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intensity <= '0;
        end else if (wr) begin
            intensity <= wr_val;
        end
    end

`ifdef SPIKE_ENC_STOCHASTIC_EN
    assign fire = (rnd < intensity);
`else
    logic [INT_W-1:0] acc;
    logic [INT_W:0]   sum;

    assign sum  = {1'b0, acc} + {1'b0, intensity};
    assign fire = sum[INT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr_evt) begin
            acc <= '0;
        end else if (tick_evt) begin
            acc <= sum[INT_W-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike <= 1'b0;
        end else begin
            spike <= tick_evt & ~clr_evt & fire;
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate encoder: prescaled timestep grid driving NUM_CH one-bit spike trains from loaded intensities.
// Latency: tick and spikes_out registered 1 cycle after the tick event. Backpressure: none; ena=0 freezes timing.
// Optional SPIKE_ENC_STOCHASTIC_EN replaces accumulator coding with a shared 16-bit Galois LFSR.
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int          NUM_CH    = NUM_CH_DEF,
    parameter int          INT_W     = INT_W_DEF,
    parameter int          TICK_DIV  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              clr,
    input  logic              load,
    input  logic [2:0]        load_ch,
    input  logic [INT_W-1:0]  load_val,
    output logic [NUM_CH-1:0] spikes_out,
    output logic              tick
);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("spike_rate_encoder: NUM_CH must be 1..8");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("spike_rate_encoder: TICK_DIV must be >= 2");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("spike_rate_encoder: LFSR_SEED must be nonzero");
    end

    localparam int               DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic              tick_evt;
    logic              clr_evt;
    logic [NUM_CH-1:0] spike_bits;

    // clr only acts while enabled, and it suppresses a coinciding tick.
    assign clr_evt  = ena & clr;
    assign tick_evt = ena & ~clr & (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= tick_evt;
            if (clr_evt) begin
                div_cnt <= '0;
            end else if (ena) begin
                div_cnt <= tick_evt ? '0 : div_cnt + 1'b1;
            end
        end
    end

`ifdef SPIKE_ENC_STOCHASTIC_EN
    lfsr_t lfsr;

    // Not cleared by clr: the random stream keeps running across clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (tick_evt) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    function automatic logic [INT_W-1:0] chan_rnd(input lfsr_t s, input int sh);
        lfsr_t r;
        r = lfsr_rotl(s, sh);
        return r[INT_W-1:0];
    endfunction
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = load & (load_ch == 3'(i));

        spike_enc_channel #(
            .INT_W (INT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick_evt (tick_evt),
            .clr_evt  (clr_evt),
            .wr       (wr),
            .wr_val   (load_val),
`ifdef SPIKE_ENC_STOCHASTIC_EN
            .rnd      (chan_rnd(lfsr, i)),
`endif
            .spike    (spike_bits[i])
        );
    end

    assign spikes_out = spike_bits;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder (NUM_CH=6, TICK_DIV=4): vector table plus hand-written phase sequences.
// Honours SPIKE_ENC_STOCHASTIC_EN by switching to the statistical rate checks.
`timescale 1ns/1ps
module tb_spike_rate_encoder;
    import snn_pkg::*;

    localparam int NCH  = 6;
    localparam int TDIV = 4;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic           ena      = 1'b0;
    logic           clr      = 1'b0;
    logic           load     = 1'b0;
    logic [2:0]     load_ch  = 3'd0;
    intensity_t     load_val = '0;
    logic [NCH-1:0] spikes_out;
    logic           tick;

    int checks = 0;
    int errors = 0;

    int             tick_cnt;
    int             stray;
    int             sp_cnt [NCH];
    logic [NCH-1:0] tick_log [$];

    typedef struct {
        logic           ena;
        logic           clr;
        logic           load;
        logic [2:0]     ch;
        intensity_t     val;
        logic           exp_tick;
        logic [NCH-1:0] exp_sp;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    spike_rate_encoder #(
        .NUM_CH    (NCH),
        .INT_W     (4),
        .TICK_DIV  (TDIV),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clr        (clr),
        .load       (load),
        .load_ch    (load_ch),
        .load_val   (load_val),
        .spikes_out (spikes_out),
        .tick       (tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic cycle(input logic e, input logic c, input logic l, input logic [2:0] ch, input intensity_t v);
        ena      = e;
        clr      = c;
        load     = l;
        load_ch  = ch;
        load_val = v;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    endtask

    task automatic clear_stats();
        tick_cnt = 0;
        stray    = 0;
        tick_log.delete();
        for (int c = 0; c < NCH; c++) sp_cnt[c] = 0;
    endtask

    task automatic note();
        if (tick) begin
            tick_cnt++;
            tick_log.push_back(spikes_out);
            for (int c = 0; c < NCH; c++) if (spikes_out[c]) sp_cnt[c]++;
        end else if (spikes_out != '0) begin
            stray++;
        end
    endtask

    initial begin
        logic [7:0] pat0;
        logic [7:0] pat3;

        // {ena, clr, load, ch, val, exp_tick, exp_spikes}
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 3'd0, 4'd8,  1'b0, 6'b000000};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 3'd1, 4'd15, 1'b0, 6'b000000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'd2, 4'd0,  1'b0, 6'b000000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  1'b1, 6'b000000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  1'b0, 6'b000000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  1'b0, 6'b000000};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  1'b0, 6'b000000};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  1'b1, 6'b000011};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'd7, 4'd15, 1'b0, 6'b000000};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 3'd6, 4'd15, 1'b0, 6'b000000};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  1'b0, 6'b000000};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 4'd0,  1'b1, 6'b000010};

        repeat (2) @(negedge clk);
        chk("reset_tick", {31'd0, tick}, 32'd0);
        chk("reset_spikes", {26'd0, spikes_out}, 32'd0);
        rst_n = 1'b1;

`ifdef SPIKE_ENC_STOCHASTIC_EN
        cycle(1'b1, 1'b0, 1'b1, 3'd0, 4'd8);
        clear_stats();
        for (int k = 0; k < 4096 * TDIV; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
            note();
        end
        chk("stoch_ticks", tick_cnt, 32'd4096);
        checks++;
        if (sp_cnt[0] < 1920 || sp_cnt[0] > 2176) begin
            errors++;
            $display("FAIL stoch_ch0_rate actual=%0d required=1920..2176", sp_cnt[0]);
        end
        chk("stoch_ch1_zero", sp_cnt[1], 32'd0);
        chk("stoch_stray", stray, 32'd0);
`else
        // Table: first tick on cycle 4, ch0=8 spikes on tick 2, ch1=15, ignored loads to ch6/ch7.
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].ena, tbl[i].clr, tbl[i].load, tbl[i].ch, tbl[i].val);
            chk($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, tbl[i].exp_tick});
            chk($sformatf("vec%0d_spikes", i), {26'd0, spikes_out}, {26'd0, tbl[i].exp_sp});
        end

        // 32 ticks of steady rate, with out-of-range loads hammered throughout.
        clear_stats();
        for (int k = 0; k < 32 * TDIV; k++) begin
            cycle(1'b1, 1'b0, 1'b1, (k % 2 == 1) ? 3'd7 : 3'd6, 4'd15);
            note();
        end
        chk("rate_ticks", tick_cnt, 32'd32);
        chk("rate_ch0", sp_cnt[0], 32'd16);
        chk("rate_ch1", sp_cnt[1], 32'd30);
        chk("rate_ch2", sp_cnt[2], 32'd0);
        for (int c = 3; c < NCH; c++) chk($sformatf("rate_ch%0d_ignored", c), sp_cnt[c], 32'd0);
        chk("rate_stray", stray, 32'd0);

        // Enable drop mid-timestep: phase must resume; clr and loads while disabled.
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("ena_pre_a", {26'd0, spikes_out}, 32'h03);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("ena_pre_b", {26'd0, spikes_out}, 32'h02);
        idle(2);
        clear_stats();
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, (k >= 5), (k == 2), 3'd5, 4'd15);
            note();
        end
        chk("ena_off_ticks", tick_cnt, 32'd0);
        chk("ena_off_stray", stray, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("ena_resume_wait", {31'd0, tick}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("ena_resume_tick", {31'd0, tick}, 32'd1);
        chk("ena_resume_spikes", {26'd0, spikes_out}, 32'h03);

        // Load coinciding with a tick event uses the old intensity.
        idle(3);
        cycle(1'b1, 1'b0, 1'b1, 3'd3, 4'd4);
        chk("ldtick_tick", {31'd0, tick}, 32'd1);
        chk("ldtick_spikes", {26'd0, spikes_out}, 32'h22);
        clear_stats();
        for (int k = 0; k < 8 * TDIV; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
            note();
        end
        chk("ldtick_count", tick_cnt, 32'd8);
        pat0 = '0;
        pat3 = '0;
        for (int t = 0; t < 8 && t < tick_log.size(); t++) begin
            pat0[t] = tick_log[t][0];
            pat3[t] = tick_log[t][3];
        end
        chk("ch3_pattern", {24'd0, pat3}, 32'h88);
        chk("ch0_pattern", {24'd0, pat0}, 32'h55);

        // clr on the tick-event cycle beats the tick; next spike two ticks later.
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
        chk("clr_tick", {31'd0, tick}, 32'd0);
        chk("clr_spikes", {26'd0, spikes_out}, 32'd0);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("clr_next_tick", {31'd0, tick}, 32'd1);
        chk("clr_next_spikes", {26'd0, spikes_out}, 32'd0);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("clr_second_spikes", {26'd0, spikes_out}, 32'h23);

        // Asynchronous reset while outputs are high, then intensities are gone.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick", {31'd0, tick}, 32'd0);
        chk("arst_spikes", {26'd0, spikes_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("post_rst_tick", {31'd0, tick}, 32'd1);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("post_rst_spikes", {26'd0, spikes_out}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
